// File: rtl/dm_pkg.sv
// Debug-module link types shared by the DTM-side initiator and the DM.
//   dtm_op_e    : access opcode (Nop / Read / Write / reserved)
//   dmi_error_e : DTM-style sticky status encoding
//   dmi_req_t   : 41-bit request  {addr[6:0], op[1:0], data[31:0]}
//   dmi_resp_t  : 34-bit response {data[31:0], resp[1:0]}
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2,
    DTM_RSVD  = 2'h3
  } dtm_op_e;

  typedef enum logic [1:0] {
    DMINoError  = 2'h0,
    DMIReserved = 2'h1,
    DMIOPFailed = 2'h2,
    DMIBusy     = 2'h3
  } dmi_error_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_initiator.sv
// DMI initiator: issues single DTM register accesses to the debug module over a
// valid/ready request channel and collects the matching response. Only one
// transaction is ever outstanding; a response timeout keeps a dead DM from
// hanging the DTM.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   dmi_clear_i                   dmireset pulse, clears sticky status
//   access_valid_i/op/addr/data   one-cycle access strobe from the DTM
//   busy_o, status_o, rdata_o     DTM-visible state
//   dmi_req_*                     request channel (valid/ready, 41-bit payload)
//   dmi_resp_*                    response channel (valid/ready, 34-bit payload)
module dmi_initiator
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_clear_i,
  input  logic        access_valid_i,
  input  logic [1:0]  access_op_i,
  input  logic [6:0]  access_addr_i,
  input  logic [31:0] access_data_i,
  output logic        busy_o,
  output logic [1:0]  status_o,
  output logic [31:0] rdata_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  state_e     state_q, state_d;
  dmi_req_t   req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  dmi_error_e status_q, status_d;
  dmi_resp_t  resp;
  logic       timeout_hit;
  logic       err_busy, err_fail;
  logic       op_is_access;

  assign resp         = dmi_resp_i;
  assign op_is_access = (access_op_i == DTM_READ) || (access_op_i == DTM_WRITE);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    err_busy = 1'b0;
    err_fail = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Responses arriving here are stale (e.g. after a timeout) and are
        // drained without effect.
        if (access_valid_i && (status_q == DMINoError) && !dmi_clear_i && op_is_access) begin
          req_d.addr = access_addr_i;
          req_d.op   = dtm_op_e'(access_op_i);
          req_d.data = access_data_i;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (dmi_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (dmi_resp_valid_i) begin
          if (resp.resp != 2'b00) begin
            err_fail = 1'b1;
          end else if (req_q.op == DTM_READ) begin
            rdata_d = resp.data;
          end
          state_d = StIdle;
        end else if (timeout_hit) begin
          err_fail = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Any access strobe while a transaction is in flight is an overrun,
    // including the cycle in which the response completes it.
    if (access_valid_i && (state_q != StIdle)) err_busy = 1'b1;
  end

  // Clear beats any same-cycle error; otherwise the first error sticks, and a
  // simultaneous overrun and failure report as Busy.
  always_comb begin
    status_d = status_q;
    if (dmi_clear_i) begin
      status_d = DMINoError;
    end else if (status_q == DMINoError) begin
      if (err_busy)      status_d = DMIBusy;
      else if (err_fail) status_d = DMIOPFailed;
    end
  end

  if (TimeoutCycles > 0) begin : g_timeout
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == StReq)       cnt_d = '0;
      else if (state_q == StWait) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == StWait) && (cnt_q == CntLast);
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      req_q    <= '0;
      rdata_q  <= '0;
      status_q <= DMINoError;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign status_o         = status_q;
  assign rdata_o          = rdata_q;
  assign dmi_req_valid_o  = (state_q == StReq);
  assign dmi_req_o        = req_q;
  assign dmi_resp_ready_o = (state_q == StIdle) || (state_q == StWait);

endmodule

// File: tb/tb_dmi_initiator.sv
module tb_dmi_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        acc_valid;
  logic [1:0]  acc_op;
  logic [6:0]  acc_addr;
  logic [31:0] acc_data;
  logic        busy;
  logic [1:0]  status;
  logic [31:0] rdata;
  logic        req_valid;
  logic        req_ready;
  logic [40:0] req;
  logic        resp_valid;
  logic        resp_ready;
  logic [33:0] resp;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  logic [40:0] exp_q[$];

  always #5 clk = ~clk;

  dmi_initiator #(.TimeoutCycles(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .dmi_clear_i      (clear),
    .access_valid_i   (acc_valid),
    .access_op_i      (acc_op),
    .access_addr_i    (acc_addr),
    .access_data_i    (acc_data),
    .busy_o           (busy),
    .status_o         (status),
    .rdata_o          (rdata),
    .dmi_req_valid_o  (req_valid),
    .dmi_req_ready_i  (req_ready),
    .dmi_req_o        (req),
    .dmi_resp_valid_i (resp_valid),
    .dmi_resp_ready_o (resp_ready),
    .dmi_resp_i       (resp)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Request-channel monitor: every accepted beat must match the next
  // expected request pushed by the stimulus.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      beats++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL req_beat: got unexpected %0h want none", req);
      end else begin
        logic [40:0] e;
        e = exp_q.pop_front();
        if (req !== e) begin
          bad++;
          $display("FAIL req_beat: got %0h want %0h", req, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                        input bit push);
    acc_valid = 1'b1;
    acc_op    = op;
    acc_addr  = a;
    acc_data  = d;
    if (push) exp_q.push_back({a, op, d});
    step();
    acc_valid = 1'b0;
    acc_op    = 2'd0;
  endtask

  task automatic handshake(input int unsigned delay);
    for (int unsigned i = 0; i < delay; i++) begin
      chk("req_hold_valid", {63'd0, req_valid}, 64'd1);
      step();
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d);
    resp_valid = 1'b1;
    resp       = {d, r};
    step();
    resp_valid = 1'b0;
    resp       = '0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    acc_valid  = 1'b0;
    acc_op     = 2'd0;
    acc_addr   = '0;
    acc_data   = '0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp       = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_busy",       {63'd0, busy}, 64'd0);
    chk("rst_status",     {62'd0, status}, 64'd0);
    chk("rst_rdata",      {32'd0, rdata}, 64'd0);
    chk("rst_req_valid",  {63'd0, req_valid}, 64'd0);
    chk("rst_req",        {23'd0, req}, 64'd0);
    chk("rst_resp_ready", {63'd0, resp_ready}, 64'd1);

    // Nop and reserved ops are ignored
    access(2'd0, 7'h10, 32'h1, 1'b0);
    chk("nop_ignored", {63'd0, busy}, 64'd0);
    access(2'd3, 7'h10, 32'h1, 1'b0);
    chk("rsvd_ignored", {63'd0, req_valid}, 64'd0);

    // 1: write, ready after 2 cycles
    access(2'd2, 7'h10, 32'h8000_0001, 1'b1);
    chk("wr_req_valid", {63'd0, req_valid}, 64'd1);
    chk("wr_req_stable", {23'd0, req}, {23'd0, 7'h10, 2'd2, 32'h8000_0001});
    handshake(2);
    chk("wr_wait_valid_low", {63'd0, req_valid}, 64'd0);
    chk("wr_wait_resp_ready", {63'd0, resp_ready}, 64'd1);
    chk("wr_wait_busy", {63'd0, busy}, 64'd1);
    respond(2'd0, 32'h1234_5678);
    chk("wr_busy_done", {63'd0, busy}, 64'd0);
    chk("wr_rdata_kept", {32'd0, rdata}, 64'd0);
    chk("wr_status", {62'd0, status}, 64'd0);
    chk("wr_beats", beats, 64'd1);

    // 2: read
    access(2'd1, 7'h11, 32'h0, 1'b1);
    handshake(0);
    step();
    chk("rd_busy_wait", {63'd0, busy}, 64'd1);
    respond(2'd0, 32'hDEAD_BEEF);
    chk("rd_rdata", {32'd0, rdata}, {32'd0, 32'hDEAD_BEEF});
    chk("rd_busy_done", {63'd0, busy}, 64'd0);

    // 3: overrun while waiting
    access(2'd1, 7'h12, 32'h0, 1'b1);
    handshake(1);
    access(2'd2, 7'h20, 32'hFFFF_FFFF, 1'b0);
    chk("ovr_status", {62'd0, status}, 64'd3);
    chk("ovr_busy", {63'd0, busy}, 64'd1);
    respond(2'd0, 32'h1111_2222);
    chk("ovr_rdata", {32'd0, rdata}, {32'd0, 32'h1111_2222});
    chk("ovr_status_kept", {62'd0, status}, 64'd3);
    access(2'd1, 7'h21, 32'h0, 1'b0);
    chk("ovr_sticky_ignored", {63'd0, req_valid}, 64'd0);
    chk("ovr_beats", beats, 64'd3);
    clear_pulse();
    chk("ovr_cleared", {62'd0, status}, 64'd0);

    // clear together with an access: access ignored
    clear = 1'b1;
    access(2'd1, 7'h22, 32'h0, 1'b0);
    clear = 1'b0;
    chk("clr_acc_ignored", {63'd0, busy}, 64'd0);

    // overrun in the response cycle still completes the read
    access(2'd1, 7'h23, 32'h0, 1'b1);
    handshake(0);
    acc_valid = 1'b1;
    acc_op    = 2'd0;
    respond(2'd0, 32'h3333_4444);
    acc_valid = 1'b0;
    chk("ovr_resp_status", {62'd0, status}, 64'd3);
    chk("ovr_resp_rdata", {32'd0, rdata}, {32'd0, 32'h3333_4444});
    clear_pulse();

    // 4: error response
    access(2'd1, 7'h13, 32'h0, 1'b1);
    handshake(0);
    respond(2'd2, 32'h0000_0055);
    chk("err_status", {62'd0, status}, 64'd2);
    chk("err_rdata_kept", {32'd0, rdata}, {32'd0, 32'h3333_4444});
    access(2'd1, 7'h13, 32'h0, 1'b0);
    chk("err_ignored_valid", {63'd0, req_valid}, 64'd0);
    step();
    chk("err_ignored_beats", beats, 64'd5);
    clear_pulse();
    chk("err_cleared", {62'd0, status}, 64'd0);
    access(2'd1, 7'h14, 32'h0, 1'b1);
    handshake(0);
    respond(2'd0, 32'hCAFE_F00D);
    chk("retry_rdata", {32'd0, rdata}, {32'd0, 32'hCAFE_F00D});
    chk("retry_status", {62'd0, status}, 64'd0);

    // 5: timeout after 8 WaitResp cycles
    access(2'd1, 7'h15, 32'h0, 1'b1);
    handshake(0);
    repeat (7) step();
    chk("to_busy_before", {63'd0, busy}, 64'd1);
    chk("to_status_before", {62'd0, status}, 64'd0);
    step();
    chk("to_busy_after", {63'd0, busy}, 64'd0);
    chk("to_status_after", {62'd0, status}, 64'd2);
    respond(2'd0, 32'h9999_9999);
    chk("late_rdata_kept", {32'd0, rdata}, {32'd0, 32'hCAFE_F00D});
    chk("late_status", {62'd0, status}, 64'd2);
    chk("late_busy", {63'd0, busy}, 64'd0);
    clear_pulse();

    // 6: asynchronous reset during Req
    access(2'd2, 7'h16, 32'hABCD_0123, 1'b0);
    chk("pre_rst_valid", {63'd0, req_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("arst_req", {23'd0, req}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_status", {62'd0, status}, 64'd0);
    chk("arst_rdata", {32'd0, rdata}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    chk("final_queue_empty", exp_q.size(), 64'd0);
    chk("final_beats", beats, 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
